// File: rtl/spi_master_lite_pkg.sv
// spi_master_lite_pkg: shared FSM state encoding and width helpers for spi_master_lite.
//   ST_*   : FSM state constants (IDLE, SETUP, HIGH, LOW, TAIL)
//   len_w  : width of a bit-count field able to hold 0..max_bits
//   sel_w  : width of a slave-index field for n selects (at least 1)
package spi_master_lite_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SETUP = 3'd1;
    localparam logic [ST_W-1:0] ST_HIGH  = 3'd2;
    localparam logic [ST_W-1:0] ST_LOW   = 3'd3;
    localparam logic [ST_W-1:0] ST_TAIL  = 3'd4;

    function automatic int unsigned len_w(input int unsigned max_bits);
        return $unsigned($clog2(max_bits + 1));
    endfunction

    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $unsigned($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/spi_master_lite_if.sv
// spi_master_lite_if: command/response handshake plus SPI pad signals.
//   cmd_valid/cmd_ready/cmd_tx/cmd_len/cmd_sel : command channel into the initiator
//   rsp_valid/rsp_data                         : one-cycle completion pulse and received bits
//   busy                                       : transfer in progress
//   spi_sck/spi_ss/spi_mosi/spi_miso           : SPI pads
//   cmd_lsb_first                              : present only when SPI_LSB_FIRST_EN is defined
// Modports: master = the SPI initiator, slave = the host/pad side facing it.
interface spi_master_lite_if
    import spi_master_lite_pkg::*;
#(
    parameter int unsigned MAX_BITS = 16,
    parameter int unsigned SS_WIDTH = 8
) ();

    localparam int unsigned LEN_W = len_w(MAX_BITS);
    localparam int unsigned SEL_W = sel_w(SS_WIDTH);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [MAX_BITS-1:0] cmd_tx;
    logic [LEN_W-1:0]    cmd_len;
    logic [SEL_W-1:0]    cmd_sel;
    logic                rsp_valid;
    logic [MAX_BITS-1:0] rsp_data;
    logic                busy;
    logic                spi_sck;
    logic [SS_WIDTH-1:0] spi_ss;
    logic                spi_mosi;
    logic                spi_miso;

`ifdef SPI_LSB_FIRST_EN
    logic                cmd_lsb_first;

    modport master (
        input  cmd_valid, cmd_tx, cmd_len, cmd_sel, cmd_lsb_first, spi_miso,
        output cmd_ready, rsp_valid, rsp_data, busy, spi_sck, spi_ss, spi_mosi
    );

    modport slave (
        output cmd_valid, cmd_tx, cmd_len, cmd_sel, cmd_lsb_first, spi_miso,
        input  cmd_ready, rsp_valid, rsp_data, busy, spi_sck, spi_ss, spi_mosi
    );
`else
    modport master (
        input  cmd_valid, cmd_tx, cmd_len, cmd_sel, spi_miso,
        output cmd_ready, rsp_valid, rsp_data, busy, spi_sck, spi_ss, spi_mosi
    );

    modport slave (
        output cmd_valid, cmd_tx, cmd_len, cmd_sel, spi_miso,
        input  cmd_ready, rsp_valid, rsp_data, busy, spi_sck, spi_ss, spi_mosi
    );
`endif

endinterface

// File: rtl/spi_master_lite_clkgen.sv
// spi_master_lite_clkgen: phase timer for the SPI FSM.
//   clock, reset_n : system clock, async active-low reset
//   run            : FSM is outside IDLE
//   reload         : FSM changes state this cycle; restart the phase
//   phase_tick_c   : high in the last cycle of each CLK_DIV-cycle phase
module spi_master_lite_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic reload,
    output logic phase_tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $unsigned($clog2(CLK_DIV)) : 1;

    logic [CNT_W-1:0] cnt;

    // Down-counter: CLK_DIV-1 on the first cycle of a phase, 0 on the last.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= CNT_W'(CLK_DIV - 1);
        end else if (reload || !run) begin
            cnt <= CNT_W'(CLK_DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign phase_tick_c = run && (cnt == '0);

endmodule

// File: rtl/spi_master_lite.sv
// spi_master_lite: CPOL=0 SPI initiator. Accepts a valid/ready command (tx bits, length, slave index),
// runs one ss-framed transfer and returns the captured miso bits as a one-cycle rsp_valid pulse.
//   clock, reset_n : system clock, async active-low reset
//   bus (master)   : command/response handshake and SPI pads, see spi_master_lite_if
// Parameters: CLK_DIV (sck half-period, >=2), MAX_BITS (max bits per transfer), SS_WIDTH (selects).
// Optional build macro SPI_LSB_FIRST_EN adds cmd_lsb_first (LSB-first bit order when set).
module spi_master_lite
    import spi_master_lite_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned MAX_BITS = 16,
    parameter int unsigned SS_WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    spi_master_lite_if.master bus
);

    localparam int unsigned LEN_W = len_w(MAX_BITS);
    localparam int unsigned SEL_W = sel_w(SS_WIDTH);

    logic [ST_W-1:0]     state;
    logic [ST_W-1:0]     state_d;
    logic                ready_q;
    logic                busy_q;
    logic                rsp_valid_q;
    logic [MAX_BITS-1:0] rsp_data_q;
    logic                sck_q;
    logic                mosi_q;
    logic [SS_WIDTH-1:0] ss_q;
    logic [MAX_BITS-1:0] tx_sh;
    logic [MAX_BITS-1:0] rx_sh;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    bit_cnt;
    logic                lsb_first;

    logic                accept_c;
    logic                run_c;
    logic                reload_c;
    logic                phase_tick_c;
    logic                enter_high_c;
    logic                leave_high_c;
    logic                finish_c;
    logic                lsb_first_c;
    logic [LEN_W-1:0]    len_eff_c;
    logic [MAX_BITS-1:0] tx_init_c;
    logic [MAX_BITS-1:0] rx_next_c;
    logic [SS_WIDTH-1:0] ss_dec_c;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_first_c = bus.cmd_lsb_first;
`else
    assign lsb_first_c = 1'b0;
`endif

    assign accept_c     = bus.cmd_valid && ready_q;
    assign run_c        = (state != ST_IDLE);
    assign reload_c     = (state_d != state);
    assign enter_high_c = phase_tick_c && (state_d == ST_HIGH);
    assign leave_high_c = phase_tick_c && (state == ST_HIGH);
    assign finish_c     = phase_tick_c && (state == ST_TAIL);

    assign len_eff_c = (bus.cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : bus.cmd_len;

    // MSB-first: pre-align cmd_tx[len-1] to the top so every bit leaves from the same position.
    assign tx_init_c = lsb_first_c ? bus.cmd_tx : (bus.cmd_tx << (LEN_W'(MAX_BITS) - len_eff_c));

    spi_master_lite_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run_c),
        .reload       (reload_c),
        .phase_tick_c (phase_tick_c)
    );

    // Slave-select decode; an out-of-range index leaves every select high.
    always_comb begin
        ss_dec_c = '1;
        for (int unsigned i = 0; i < SS_WIDTH; i++) begin
            if (SEL_W'(i) == bus.cmd_sel) begin
                ss_dec_c[i] = 1'b0;
            end
        end
    end

    // Receive shift: MSB-first enters at bit 0, LSB-first enters at bit len-1; both end right-aligned.
    always_comb begin
        rx_next_c = {rx_sh[MAX_BITS-2:0], bus.spi_miso};
        if (lsb_first) begin
            rx_next_c = (rx_sh >> 1) | (MAX_BITS'(bus.spi_miso) << (len_q - LEN_W'(1)));
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; a zero-length command completes without leaving IDLE.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (accept_c && (len_eff_c != '0)) state_d = ST_SETUP;
            ST_SETUP: if (phase_tick_c) state_d = ST_HIGH;
            ST_HIGH:  if (phase_tick_c) state_d = ST_LOW;
            ST_LOW:   if (phase_tick_c) state_d = (bit_cnt == '0) ? ST_TAIL : ST_HIGH;
            ST_TAIL:  if (phase_tick_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake, shift registers and registered SPI outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b1;
            ss_q        <= '1;
            tx_sh       <= '0;
            rx_sh       <= '0;
            len_q       <= '0;
            bit_cnt     <= '0;
            lsb_first   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;

            if (accept_c) begin
                ready_q   <= 1'b0;
                busy_q    <= 1'b1;
                len_q     <= len_eff_c;
                bit_cnt   <= len_eff_c;
                tx_sh     <= tx_init_c;
                rx_sh     <= '0;
                lsb_first <= lsb_first_c;
                if (len_eff_c == '0) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                end else begin
                    ss_q <= ss_dec_c;
                end
            end else if ((state == ST_IDLE) && !ready_q) begin
                // One cycle after the response pulse the block reopens for commands.
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end

            // Rising sck: present the next tx bit and sample miso in the same clock.
            if (enter_high_c) begin
                sck_q   <= 1'b1;
                mosi_q  <= lsb_first ? tx_sh[0] : tx_sh[MAX_BITS-1];
                tx_sh   <= lsb_first ? (tx_sh >> 1) : (tx_sh << 1);
                rx_sh   <= rx_next_c;
                bit_cnt <= bit_cnt - LEN_W'(1);
            end

            if (leave_high_c) begin
                sck_q <= 1'b0;
            end

            if (finish_c) begin
                ss_q        <= '1;
                mosi_q      <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rx_sh;
            end
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.spi_sck   = sck_q;
    assign bus.spi_mosi  = mosi_q;
    assign bus.spi_ss    = ss_q;

endmodule
